// File: rtl/clock_divider_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// The output-mode encoding is the per-channel meaning of the mode bus.
package clock_divider_pkg;

  localparam int NUM_CH_DEF      = 4;
  localparam int CNT_W_DEF       = 16;
  localparam int DEFAULT_DIV_DEF = 20;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  // Next output level: pulse mode mirrors the wrap strobe, toggle mode flips on it.
  function automatic logic next_cout(input logic mode, input logic cout, input logic wrap);
    logic r;
    if (mode == MODE_PULSE)
      r = wrap;
    else
      r = cout ^ wrap;
    return r;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: wrap counter, shadowed divisor load and registered outputs.
// The divisor only changes while the counter is (or becomes) zero, so cnt never exceeds it.
module clk_div_channel
  import clock_divider_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             mode,
  input  logic             div_wr,
  input  logic [CNT_W-1:0] div_data,
  output logic             div_pend,
  output logic             tick,
  output logic             cout
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_act;
  logic [CNT_W-1:0] shadow;
  logic             pend;
  logic             tick_r;
  logic             cout_r;
  logic             wrap;
  logic             load;

  assign wrap = en & ~sync & (cnt == div_act);
  // A pending divisor becomes active whenever the counter is forced or wraps to zero.
  assign load = pend & (sync | ~en | wrap);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      div_act <= CNT_W'(DEFAULT_DIV);
      shadow  <= CNT_W'(DEFAULT_DIV);
      pend    <= 1'b0;
      tick_r  <= 1'b0;
      cout_r  <= 1'b0;
    end else begin
      if (sync) begin
        cnt    <= '0;
        tick_r <= 1'b0;
        cout_r <= 1'b0;
      end else if (!en) begin
        cnt    <= '0;
        tick_r <= 1'b0;
      end else begin
        cnt    <= wrap ? '0 : cnt + CNT_W'(1);
        tick_r <= wrap;
        cout_r <= next_cout(mode, cout_r, wrap);
      end

      if (load)
        div_act <= shadow;

      // A write on the load edge keeps pend set: the new value waits for the next wrap.
      if (div_wr) begin
        shadow <= div_data;
        pend   <= 1'b1;
      end else if (load) begin
        pend   <= 1'b0;
      end
    end
  end

  assign div_pend = pend;
  assign tick     = tick_r;
  assign cout     = cout_r;

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel clock-enable / divided-clock generator.
// Slices the per-channel buses and fans out rst, sync and the shared div_data.
module clock_divider_multi
  import clock_divider_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic              cin,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic [NUM_CH-1:0] mode,
  input  logic [NUM_CH-1:0] div_wr,
  input  logic [CNT_W-1:0]  div_data,
  output logic [NUM_CH-1:0] div_pend,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] cout
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk      (cin),
      .rst      (rst),
      .en       (en[g]),
      .sync     (sync),
      .mode     (mode[g]),
      .div_wr   (div_wr[g]),
      .div_data (div_data),
      .div_pend (div_pend[g]),
      .tick     (tick[g]),
      .cout     (cout[g])
    );
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Randomized bench for clock_divider_multi against a period-position reference model.
module tb_clock_divider_multi;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int DEFDIV = 20;

  logic              cin = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] en;
  logic              sync;
  logic [NUM_CH-1:0] mode;
  logic [NUM_CH-1:0] div_wr;
  logic [CNT_W-1:0]  div_data;
  logic [NUM_CH-1:0] div_pend;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] cout;

  clock_divider_multi #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFDIV)
  ) dut (
    .cin      (cin),
    .rst      (rst),
    .en       (en),
    .sync     (sync),
    .mode     (mode),
    .div_wr   (div_wr),
    .div_data (div_data),
    .div_pend (div_pend),
    .tick     (tick),
    .cout     (cout)
  );

  always #5 cin = ~cin;

  // Reference state: position inside the current period, period length, queued period.
  int m_pos    [NUM_CH];
  int m_period [NUM_CH];
  int m_next   [NUM_CH];
  bit m_queued [NUM_CH];
  bit m_tick   [NUM_CH];
  bit m_out    [NUM_CH];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_pos[c]    = 0;
      m_period[c] = DEFDIV + 1;
      m_next[c]   = DEFDIV + 1;
      m_queued[c] = 0;
      m_tick[c]   = 0;
      m_out[c]    = 0;
    end
  endtask

  // Applies one clock edge using the inputs currently driven.
  task automatic model_step();
    bit end_of_period;
    bit restart;
    if (rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      restart       = sync || !en[c];
      end_of_period = !restart && (m_pos[c] + 1 == m_period[c]);
      if (m_queued[c] && (restart || end_of_period)) begin
        m_period[c] = m_next[c];
        m_queued[c] = 0;
      end
      if (restart) begin
        m_pos[c]  = 0;
        m_tick[c] = 0;
        if (sync) m_out[c] = 0;
      end else begin
        m_pos[c]  = end_of_period ? 0 : m_pos[c] + 1;
        m_tick[c] = end_of_period;
        if (mode[c]) m_out[c] = end_of_period;
        else if (end_of_period) m_out[c] = !m_out[c];
      end
      if (div_wr[c]) begin
        m_next[c]   = int'(div_data) + 1;
        m_queued[c] = 1;
      end
    end
  endtask

  task automatic compare_all();
    logic [NUM_CH-1:0] e_tick, e_cout, e_pend;
    for (int c = 0; c < NUM_CH; c++) begin
      e_tick[c] = m_tick[c];
      e_cout[c] = m_out[c];
      e_pend[c] = m_queued[c];
    end
    chk("tick", 32'(tick), 32'(e_tick));
    chk("cout", 32'(cout), 32'(e_cout));
    chk("div_pend", 32'(div_pend), 32'(e_pend));
  endtask

  task automatic cycle();
    @(posedge cin);
    model_step();
    @(negedge cin);
    compare_all();
  endtask

  initial begin
    rst      = 1'b1;
    en       = '0;
    sync     = 1'b0;
    mode     = '0;
    div_wr   = '0;
    div_data = '0;
    model_reset();
    cycle();
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_cout", 32'(cout), 32'h0);
    chk("rst_pend", 32'(div_pend), 32'h0);
    cycle();

    // Channel 0 alone at the default divisor, toggle mode.
    rst = 1'b0;
    en  = 4'b0001;
    for (int i = 0; i < 28; i++) cycle();
    // Divisor 4 written mid-period: current period completes first.
    div_wr   = 4'b0001;
    div_data = 16'd4;
    cycle();
    div_wr = '0;
    for (int i = 0; i < 60; i++) cycle();

    // Sync with channels at assorted divisors, some in pulse mode.
    en   = 4'b1111;
    mode = 4'b1010;
    for (int c = 0; c < NUM_CH; c++) begin
      div_wr   = '0;
      div_wr[c] = 1'b1;
      div_data = CNT_W'((c == 2) ? 0 : 3 * c + 2);
      cycle();
    end
    div_wr = '0;
    for (int i = 0; i < 30; i++) cycle();
    sync = 1'b1;
    cycle();
    sync = 1'b0;
    for (int i = 0; i < 25; i++) cycle();

    // Random traffic.
    for (int i = 0; i < 2500; i++) begin
      rst  = ($urandom_range(0, 399) == 0);
      sync = ($urandom_range(0, 59) == 0);
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 19) == 0) en[c] = ~en[c];
        if ($urandom_range(0, 29) == 0) mode[c] = ~mode[c];
        div_wr[c] = ($urandom_range(0, 24) == 0);
      end
      div_data = ($urandom_range(0, 7) == 0) ? CNT_W'($urandom_range(0, 40))
                                              : CNT_W'($urandom_range(0, 9));
      cycle();
    end

    // Mid-period reset with a pending load discards it.
    rst      = 1'b0;
    sync     = 1'b0;
    en       = 4'b1111;
    div_wr   = 4'b1111;
    div_data = 16'd3;
    cycle();
    div_wr = '0;
    for (int i = 0; i < 2; i++) cycle();
    rst = 1'b1;
    cycle();
    chk("rst2_pend", 32'(div_pend), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
